// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: sync inputs and decoded outputs; master drives syncs, slave decodes
interface vga_sync_decoder_if;
    logic       hsync;
    logic       vsync;
    logic       activevideo;
    logic [9:0] x_px;
    logic [9:0] y_px;
    logic       pixel_valid;
    logic       frame_start;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       locked;
    logic       sync_err;
    modport master (
        output hsync, vsync, activevideo,
        input  x_px, y_px, pixel_valid, frame_start, line_len, frame_lines, locked, sync_err
    );
    modport slave (
        input  hsync, vsync, activevideo,
        output x_px, y_px, pixel_valid, frame_start, line_len, frame_lines, locked, sync_err
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates and timing lock from VGA syncs (px_clk, reset sync high; bus carries syncs in, x/y/valid/frame_start/line_len/frame_lines/locked/sync_err out)
module vga_sync_decoder #(
    parameter int MAX_CNT = 1023
) (
    input logic px_clk,
    input logic reset,
    vga_sync_decoder_if.slave bus
);
    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] MEASURE  = 2'd1;
    localparam logic [1:0] LOCKED   = 2'd2;
    localparam logic [9:0] MAX      = 10'(MAX_CNT);

    // {hsync, vsync, activevideo}; idle value keeps reset from forming false edges
    logic [2:0]  s1_q, s1_d, s2_q, s2_d;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, y_cnt_q, y_cnt_d, xc_q, xc_d;
    logic        h_seen_q, h_seen_d, pv_q, pv_d, have_len_q, have_len_d;
    logic [1:0]  state_q, state_d;
    logic [9:0]  line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic        pixel_valid_q, pixel_valid_d, frame_start_q, frame_start_d, sync_err_q, sync_err_d;
    logic [9:0]  x_px_q, x_px_d, y_px_q, y_px_d;
    logic        hs_fall, vs_fall, av_rise, av_fall, per_v, per_bad, lock_err;
    logic [10:0] period;

    always_comb begin
        hs_fall  = s2_q[2] & ~s1_q[2];
        vs_fall  = s2_q[1] & ~s1_q[1];
        av_rise  = s1_q[0] & ~s2_q[0];
        av_fall  = s2_q[0] & ~s1_q[0];
        s1_d     = {bus.hsync, bus.vsync, bus.activevideo};
        s2_d     = s1_q;
        // period is only meaningful once a previous falling edge has been seen
        period   = {1'b0, h_cnt_q} + 11'd1;
        per_v    = hs_fall & h_seen_q;
        per_bad  = per_v && period != {1'b0, line_len_q};
        lock_err = per_bad || (vs_fall && v_cnt_q != frame_lines_q) || h_cnt_q == MAX;
        h_seen_d = h_seen_q | hs_fall;
        h_cnt_d  = hs_fall ? 10'd0 : h_cnt_q == MAX ? h_cnt_q : h_cnt_q + 10'd1;
        // a coincident hsync edge belongs to the new frame as its first line
        v_cnt_d  = vs_fall ? (hs_fall ? 10'd1 : 10'd0) :
                   (hs_fall && v_cnt_q != MAX) ? v_cnt_q + 10'd1 : v_cnt_q;
        y_cnt_d  = vs_fall ? 10'd0 : av_fall ? y_cnt_q + 10'd1 : y_cnt_q;
        pv_d     = s1_q[0];
        xc_d     = av_rise ? 10'd0 : s1_q[0] ? xc_q + 10'd1 : xc_q;
        state_d       = state_q;
        have_len_d    = have_len_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        sync_err_d    = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (vs_fall) begin
                    state_d    = MEASURE;
                    have_len_d = 1'b0;
                end
            end
            MEASURE: begin
                if (per_v && !have_len_q) begin
                    line_len_d = period[9:0];
                    have_len_d = 1'b1;
                end else if (per_bad) begin
                    state_d = UNLOCKED;
                end
                if (vs_fall && have_len_q && !per_bad) begin
                    state_d       = LOCKED;
                    frame_lines_d = v_cnt_q;
                end
            end
            LOCKED: begin
                if (lock_err) begin
                    state_d    = UNLOCKED;
                    sync_err_d = 1'b1;
                end
            end
            default: state_d = UNLOCKED;
        endcase
        // output stage: state_d lands in state_q on the same edge, so frame_start aligns with locked
        pixel_valid_d = pv_q;
        x_px_d        = pv_q ? xc_q : 10'd0;
        y_px_d        = pv_q ? y_cnt_q : 10'd0;
        frame_start_d = pv_q && xc_q == 10'd0 && y_cnt_q == 10'd0 && state_d == LOCKED;
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            s1_q          <= 3'b110;
            s2_q          <= 3'b110;
            h_cnt_q       <= '0;
            h_seen_q      <= 1'b0;
            v_cnt_q       <= '0;
            y_cnt_q       <= '0;
            pv_q          <= 1'b0;
            xc_q          <= '0;
            state_q       <= UNLOCKED;
            have_len_q    <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            pixel_valid_q <= 1'b0;
            x_px_q        <= '0;
            y_px_q        <= '0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            h_cnt_q       <= h_cnt_d;
            h_seen_q      <= h_seen_d;
            v_cnt_q       <= v_cnt_d;
            y_cnt_q       <= y_cnt_d;
            pv_q          <= pv_d;
            xc_q          <= xc_d;
            state_q       <= state_d;
            have_len_q    <= have_len_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            pixel_valid_q <= pixel_valid_d;
            x_px_q        <= x_px_d;
            y_px_q        <= y_px_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus.x_px        = x_px_q;
    assign bus.y_px        = y_px_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.line_len    = line_len_q;
    assign bus.frame_lines = frame_lines_q;
    assign bus.locked      = state_q == LOCKED;
    assign bus.sync_err    = sync_err_q;
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter MAX_CNT, default 1023, giving the saturation value of the horizontal and line period counters.
REQ-002 SHALL have port px_clk, input, 1 bit: pixel clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port hsync, input, 1 bit: horizontal sync, active low.
REQ-005 SHALL have port vsync, input, 1 bit: vertical sync, active low.
REQ-006 SHALL have port activevideo, input, 1 bit: source data-enable.
REQ-007 SHALL have port x_px, output, 10 bits: recovered column of the current active pixel.
REQ-008 SHALL have port y_px, output, 10 bits: recovered row of the current active pixel.
REQ-009 SHALL have port pixel_valid, output, 1 bit: x_px/y_px refer to an active pixel.
REQ-010 SHALL have port frame_start, output, 1 bit: one-cycle pulse on pixel (0,0).
REQ-011 SHALL have port line_len, output, 10 bits: measured hsync period in px_clk cycles.
REQ-012 SHALL have port frame_lines, output, 10 bits: measured hsync edges per vsync period.
REQ-013 SHALL have port locked, output, 1 bit: timing is stable.
REQ-014 SHALL have port sync_err, output, 1 bit: one-cycle pulse on loss of lock.

Function
REQ-015 SHALL register hsync, vsync and activevideo once, then detect edges from that registered stage and the stage before it; no other input path.
REQ-016 SHALL assert pixel_valid exactly 2 px_clk cycles after the activevideo sample it represents.
REQ-017 SHALL set x_px to 0 for the first active pixel after each activevideo rising edge, and add 1 for each later active pixel in that line.
REQ-018 SHALL set y_px to 0 for the first active line after a vsync falling edge, and add 1 at each activevideo falling edge.
REQ-019 SHALL drive x_px=0 and y_px=0 whenever pixel_valid=0.
REQ-020 SHALL pulse frame_start with pixel_valid=1, x_px=0, y_px=0, and only when locked=1.
REQ-021 SHALL run a horizontal counter that clears on each hsync falling edge, increments otherwise, and saturates at MAX_CNT.
REQ-022 SHALL take each hsync period as (counter value at the falling edge)+1, counted between consecutive falling edges.
REQ-023 SHALL run a line counter that counts hsync falling edges, clears on each vsync falling edge, and saturates at MAX_CNT.
REQ-024 SHALL, when a vsync falling edge and an hsync falling edge occur in the same cycle, clear the line counter to 1 (the hsync edge counts as line 1).
REQ-025 SHALL use a three-state FSM: UNLOCKED, MEASURE, LOCKED.
REQ-026 SHALL, in UNLOCKED, go to MEASURE on a vsync falling edge.
REQ-027 SHALL, in MEASURE, store the first hsync period into line_len, and restart the measurement if any later period in the frame differs.
REQ-028 SHALL, in MEASURE, at the next vsync falling edge with all periods equal, store the line count into frame_lines and go to LOCKED.
REQ-029 SHALL, in LOCKED, go to UNLOCKED and pulse sync_err for 1 cycle on any of: a period different from line_len; a vsync edge with line count different from frame_lines; a saturated horizontal counter.
REQ-030 SHALL hold line_len and frame_lines at their last values after loss of lock.
REQ-031 SHALL assert locked only in the LOCKED state; pixel_valid and x_px/y_px operate whatever the FSM state.

Reset
REQ-032 SHALL, while reset=1 at a clock edge, drive all outputs to 0, set the FSM to UNLOCKED, and clear all counters and input pipeline registers.
REQ-033 SHALL, on reset asserted mid-frame, discard any partial measurement and require a full new frame before locked=1.
REQ-034 SHALL ignore edges formed between pre-reset and post-reset samples (the pipeline starts as hsync=vsync=1, activevideo=0).

Verification
REQ-035 SHALL check lock: drive 640x480 timing (816 px/line, 524 lines, hsync low 96 cycles, vsync low 2 lines) -> locked=1 at the second vsync falling edge after reset, line_len=816, frame_lines=524.
REQ-036 SHALL check pixel indexing: with the bench locked -> one frame_start per frame; last pixel x_px=639, y_px=479; pixel_valid high 640 cycles per line, 2 cycles after activevideo.
REQ-037 SHALL check a long line: while locked, stretch one line to 817 cycles -> sync_err pulse of 1 cycle, locked=0, line_len stays 816, relock after two clean vsync edges.
REQ-038 SHALL check loss of hsync: hold hsync=1 while locked -> sync_err when the counter reaches 1023, locked=0.
REQ-039 SHALL check reset mid-frame: assert reset for 1 cycle at line 200 -> all outputs 0 the next cycle; locked=0 until the second vsync falling edge after reset.
REQ-040 SHALL check a wrong frame length: while locked, send a frame with 523 lines -> sync_err at that vsync falling edge, frame_lines stays 524.
